// File: rtl/packet_disassembler.sv
// ============================================================================
// Module   : packet_disassembler
// Purpose  : Rebuilds HDMI data island packets (header + 4 subpackets) from
//            TERC4-decoded 9-bit words and checks the five BCH parity bytes.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module packet_disassembler #(
    parameter bit CHECK_ECC     = 1'b1,
    parameter bit DROP_ON_ERROR = 1'b0
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        data_island_period,
    input  logic [8:0]  packet_data,
    output logic [23:0] header,
    output logic [55:0] sub [3:0],
    output logic [4:0]  ecc_error,
    output logic        packet_valid
);

    localparam logic [7:0] c_POLY       = 8'h83;
    localparam logic [4:0] c_HDR_WORDS  = 5'd24;
    localparam logic [4:0] c_SUB_WORDS  = 5'd28;
    localparam logic [4:0] c_LAST_WORD  = 5'd31;

    logic [4:0]  r_word;
    logic [23:0] r_hdr;
    logic [6:0]  r_hdr_par;
    logic [7:0]  r_hdr_ecc;
    logic [55:0] r_blk [4];
    logic [5:0]  r_par [4];
    logic [7:0]  r_ecc [4];

    logic [7:0]  w_hdr_ecc_next;
    logic [7:0]  w_hdr_par_full;
    logic [7:0]  w_sub_ecc_next [4];
    logic [7:0]  w_sub_par_full [4];
    logic [4:0]  w_err;

    function automatic logic [7:0] f_ecc_step(input logic [7:0] e, input logic b);
        return (e[0] ^ b) ? ({1'b0, e[7:1]} ^ c_POLY) : {1'b0, e[7:1]};
    endfunction

    // Word 0 seeds every BCH register from zero so back-to-back packets need no idle gap.
    always_comb begin
        w_hdr_ecc_next = f_ecc_step((r_word == 5'd0) ? 8'h00 : r_hdr_ecc, packet_data[0]);
        w_hdr_par_full = {packet_data[0], r_hdr_par};
        w_err          = '0;
        for (int i = 0; i < 4; i++) begin
            w_sub_ecc_next[i] = f_ecc_step(f_ecc_step((r_word == 5'd0) ? 8'h00 : r_ecc[i],
                                                      packet_data[1+i]), packet_data[5+i]);
            w_sub_par_full[i] = {packet_data[5+i], packet_data[1+i], r_par[i]};
            if (CHECK_ECC)
                w_err[i] = (w_sub_par_full[i] != r_ecc[i]);
        end
        if (CHECK_ECC)
            w_err[4] = (w_hdr_par_full != r_hdr_ecc);
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_word       <= '0;
            r_hdr        <= '0;
            r_hdr_par    <= '0;
            r_hdr_ecc    <= '0;
            header       <= '0;
            ecc_error    <= '0;
            packet_valid <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_blk[i] <= '0;
                r_par[i] <= '0;
                r_ecc[i] <= '0;
                sub[i]   <= '0;
            end
        end else begin
            packet_valid <= 1'b0;
            if (!data_island_period) begin
                r_word <= '0;
            end else begin
                r_word <= r_word + 5'd1;
                // Shift registers fill LSB-first; every bit is overwritten each packet.
                if (r_word < c_HDR_WORDS) begin
                    r_hdr     <= {packet_data[0], r_hdr[23:1]};
                    r_hdr_ecc <= w_hdr_ecc_next;
                end else begin
                    r_hdr_par <= {packet_data[0], r_hdr_par[6:1]};
                end
                for (int i = 0; i < 4; i++) begin
                    if (r_word < c_SUB_WORDS) begin
                        r_blk[i] <= {packet_data[5+i], packet_data[1+i], r_blk[i][55:2]};
                        r_ecc[i] <= w_sub_ecc_next[i];
                    end else begin
                        r_par[i] <= {packet_data[5+i], packet_data[1+i], r_par[i][5:2]};
                    end
                end
                if (r_word == c_LAST_WORD) begin
                    header    <= r_hdr;
                    ecc_error <= w_err;
                    for (int i = 0; i < 4; i++)
                        sub[i] <= r_blk[i];
                    packet_valid <= !(DROP_ON_ERROR && (|w_err));
                end
            end
        end
    end

endmodule

`default_nettype wire
